display_step_ctrl: RTL and testbench
====================================

# display_step_ctrl

Board-side companion to the pipelined MIPS core. It consumes the core's debug outputs (`currentPC`, `s0`–`s7`, `t0`–`t9`) and shows one selected 16-bit half-word in hex on a 4-digit multiplexed seven-segment display. It also debounces a push-button and emits a single-cycle `cpu_step` pulse, which steps the core one instruction per press.

## Interface

Reset is synchronous and active-low. The block uses one clock. Both are fixed decisions.

Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit is lit (≥2).
- `DEBOUNCE_CYCLES`, default 1000000: the level must be stable for this many cycles to count as a press or a release (≥2).

Ports (active-low outputs):
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `btn_step`  in  1  raw asynchronous push-button, high = pressed
- `sel`  in  5  source select: 0 = `currentPC`, 1–8 = `s0`–`s7`, 9–18 = `t0`–`t9`, 19–31 = invalid
- `half`  in  1  0 = bits [15:0], 1 = bits [31:16]
- `currentPC`, `s0`…`s7`, `t0`…`t9`  in  32 each  core debug values
- `cpu_step`  out  1  one-cycle step pulse to the core
- `an`  out  4  digit enables, active-low; `an[0]` is the rightmost digit
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low
- `dp`  out  1  decimal point, active-low

## Operation

**Value path**
- `disp_val[15:0]` is registered every cycle from the selected source and half.
- An invalid `sel` sets an `invalid` flag (registered in the same cycle).

**Scan**
- `div_cnt` counts 0..`REFRESH_DIV`-1 and then wraps.
- On wrap, `dig` (2 bits) advances 0→1→2→3→0.
- Digit `d` shows `disp_val[4d+3:4d]`.

**Outputs (registered)**
- `an` = ~(1<<`dig`).
- Hex segments, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- When `invalid` is set, every digit shows a dash, 0111111.
- `dp` = 0 only when `dig`==0 and `half`==1 (high-half indicator). Otherwise `dp` = 1.

**Debounce FSM**
- `btn_step` passes through a 2-flop synchronizer; its output is `b`.
- A counter `cnt` runs alongside the FSM. Transitions:
  - IDLE: `b`=1 → WAIT_PRESS, `cnt`=0.
  - WAIT_PRESS: `b`=0 → IDLE. Otherwise `cnt`++. At `cnt`==`DEBOUNCE_CYCLES`-1 → PRESSED, and assert `cpu_step` for exactly that next cycle.
  - PRESSED: `b`=0 → WAIT_RELEASE, `cnt`=0.
  - WAIT_RELEASE: `b`=1 → PRESSED. Otherwise `cnt`++. At `cnt`==`DEBOUNCE_CYCLES`-1 → IDLE.
- Holding the button produces exactly one pulse. Bounces shorter than `DEBOUNCE_CYCLES` produce none.
- Counters saturate and never wrap inside a state.

**Reset (`rst_n`=0 at an edge)**
- Outputs: `an`=1111, `seg`=1111111, `dp`=1, `cpu_step`=0.
- Internal state: FSM=IDLE, `cnt`=0, `div_cnt`=0, `dig`=0, `disp_val`=0, `invalid`=0, synchronizer flops=0.
- A reset mid-debounce drops any pending pulse.
- A reset in the same cycle as a pulse forces `cpu_step`=0.

## Timing

**Display latency**
- Source or `sel` change → `disp_val` updates after 1 edge → `seg` updates after 2 edges, provided the affected digit is lit.
- First edge after reset release: `an`=1110 and `seg` shows digit 0 of `disp_val`.
- `an` changes exactly every `REFRESH_DIV` cycles. Exactly one digit is enabled at all times outside reset.

**Press latency**
- Edge 1 is the first edge that samples `btn_step`=1.
- `b`=1 after edge 2. WAIT_PRESS is entered at edge 3.
- `cpu_step` is high for the single cycle following edge `DEBOUNCE_CYCLES`+3, provided `btn_step` is held continuously.

**Release latency**
- After release is confirmed (`DEBOUNCE_CYCLES` stable-low cycles), the next press is accepted from IDLE.

**Simultaneous events**
- A `half` or `sel` change during a digit wrap is applied to the new digit one cycle late. No glitch on `an` is allowed.

## Test plan

Use `REFRESH_DIV`=4 and `DEBOUNCE_CYCLES`=4.

1. **Reset**
   - Stimulus: hold `rst_n`=0 for 3 cycles with `btn_step`=1.
   - Required: `an`=1111, `seg`=1111111, `dp`=1, `cpu_step`=0 throughout; no pulse for the held press until it is released and pressed again.
2. **Scan PC**
   - Stimulus: `sel`=0, `half`=0, `currentPC`=0x0040_1A3C.
   - Required: `an` cycles 1110→1101→1011→0111 every 4 cycles. `seg` is C (1000110), 3 (0110000), A (0001000), 1 (1111001) respectively. `dp`=1.
3. **High half and invalid select**
   - Stimulus: `sel`=9, `half`=1, `t0`=0xBEEF_0000.
   - Required: digits read F, E, E, b; `dp`=0 only while `an`=1110.
   - Then set `sel`=25: all digits show 0111111 within 2 cycles.
4. **Clean press**
   - Stimulus: `btn_step` 0→1, held 20 cycles.
   - Required: exactly one `cpu_step` pulse, in the cycle after edge 7, width 1.
5. **Bounce rejection**
   - Stimulus: `btn_step` toggles 1,0,1,0 at 2-cycle intervals, then settles at 1 for 10 cycles.
   - Required: exactly one pulse, occurring 7 edges after the settle edge.
   - Release bounces shorter than 4 cycles produce no extra pulse.
6. **Reset mid-debounce**
   - Stimulus: press; assert `rst_n`=0 at edge 5 for 1 cycle while still held.
   - Required: `cpu_step` never asserts until a release followed by a new press.

Source files
------------

// File: rtl/display_step_ctrl_if.sv
// display_step_ctrl_if: core debug values in, display and step pulse out
interface display_step_ctrl_if;
    logic [4:0]       sel;
    logic             half;
    logic [31:0]      current_pc;
    logic [7:0][31:0] s;
    logic [9:0][31:0] t;
    logic             cpu_step;
    logic [3:0]       an;
    logic [6:0]       seg;
    logic             dp;
    modport master (output sel, half, current_pc, s, t, input cpu_step, an, seg, dp);
    modport slave  (input sel, half, current_pc, s, t, output cpu_step, an, seg, dp);
endinterface

// File: rtl/display_step_ctrl.sv
// display_step_ctrl: hex view of a core debug register plus debounced single-step button
module display_step_ctrl #(
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input logic                i_clk,
    input logic                i_rst_n,
    input logic                i_btn_step,
    display_step_ctrl_if.slave bus
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DMAX = DW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0][6:0] HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_step_nxt, r_step;
    logic [DW-1:0] r_div_cnt;
    logic [1:0]    r_dig;
    logic [15:0]   r_disp_val;
    logic          r_invalid;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [1:0]    r_sync;
    logic [1:0]    r_fill;
    logic          r_armed;
    logic          w_b;
    logic [2:0]    w_s_idx;
    logic [3:0]    w_t_idx;
    logic [31:0]   w_src;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;
    assign w_b     = r_sync[1];
    assign w_s_idx = 3'(bus.sel - 5'd1);
    assign w_t_idx = 4'(bus.sel - 5'd9);
    assign w_src   = (bus.sel == 5'd0) ? bus.current_pc :
                     (bus.sel <= 5'd8) ? bus.s[w_s_idx] :
                     (bus.sel <= 5'd18) ? bus.t[w_t_idx] : 32'd0;
    assign w_nib   = r_disp_val[{r_dig, 2'b00} +: 4];
    assign w_seg   = r_invalid ? 7'b0111111 : HEX[w_nib];
    assign bus.cpu_step = r_step;
    assign bus.an       = r_an;
    assign bus.seg      = r_seg;
    assign bus.dp       = r_dp;
    // capture the selected half-word and flag out-of-range selects
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_disp_val <= '0;
            r_invalid  <= 1'b0;
        end else begin
            r_disp_val <= bus.half ? w_src[31:16] : w_src[15:0];
            r_invalid  <= bus.sel > 5'd18;
        end
    end
    // refresh divider; the lit digit advances on each wrap
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_dig     <= '0;
        end else begin
            r_div_cnt <= (r_div_cnt == DMAX) ? '0 : r_div_cnt + 1'b1;
            r_dig     <= (r_div_cnt == DMAX) ? r_dig + 1'b1 : r_dig;
        end
    end
    // registered display drive; dp marks digit 0 while the high half is shown
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(4'b0001 << r_dig);
            r_seg <= w_seg;
            r_dp  <= !(r_dig == 2'd0 && bus.half);
        end
    end
    // synchronizer; a button still held across reset must be seen released before it can step
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_step};
            r_fill  <= (r_fill == 2'd2) ? r_fill : r_fill + 1'b1;
            r_armed <= r_armed | (r_fill == 2'd2 && !w_b);
        end
    end
    // debounce state, counter and step pulse registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_step  <= w_step_nxt;
        end
    end
    // debounce transitions; the counter saturates at its terminal value
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_b && r_armed) begin
                    w_state_nxt = WAIT_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!w_b) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CMAX) begin
                    w_state_nxt = PRESSED;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_b) begin
                    w_state_nxt = WAIT_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (w_b) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CMAX) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_display_step_ctrl.sv
// tb_display_step_ctrl: scoreboard bench for the scan display and step debouncer
module tb_display_step_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    int   cyc = 0;
    int   rel = 0;
    logic rst_q = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] prev_an = 4'b1111;
    int          pq[$];
    logic [11:0] dq[$];

    display_step_ctrl_if bus();

    display_step_ctrl #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(4)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_btn_step(btn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // cycle counter; rel is the first edge that samples reset released
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
        if (!rst_n) rel <= cyc + 2;
    end

    // monitor: reset values, step pulses and digit changes checked against queues
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (!rst_q) begin
                checks++;
                if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.dp !== 1'b1 || bus.cpu_step !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_out cyc=%0d got an=%b seg=%b dp=%b step=%b want an=1111 seg=1111111 dp=1 step=0",
                             cyc, bus.an, bus.seg, bus.dp, bus.cpu_step);
                end
            end else begin
                if (bus.cpu_step === 1'b1) begin
                    checks++;
                    if (pq.size() == 0) begin
                        failures++;
                        $display("FAIL step_unexpected cyc=%0d got pulse want none", cyc);
                    end else begin
                        int e;
                        e = pq.pop_front();
                        if (cyc != e) begin
                            failures++;
                            $display("FAIL step_time got cyc=%0d want cyc=%0d", cyc, e);
                        end
                    end
                end
                if (bus.an !== prev_an && dq.size() > 0) begin
                    logic [11:0] e;
                    e = dq.pop_front();
                    checks++;
                    if ({bus.an, bus.seg, bus.dp} !== e) begin
                        failures++;
                        $display("FAIL digit cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                                 cyc, bus.an, bus.seg, bus.dp, e[11:8], e[7:1], e[0]);
                    end
                end
            end
            prev_an = bus.an;
        end
    end

    function automatic logic [11:0] ent(input logic [1:0] d, input logic [6:0] s, input logic p);
        logic [3:0] one;
        one = 4'b0001;
        return {~(one << d), s, p};
    endfunction

    // let inputs settle, then expect the four digits starting at the next digit-0 change
    task automatic show(input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2, input logic [11:0] e3);
        repeat (3) @(negedge clk);
        while (cyc < rel || ((cyc + 1 - rel) % 16) != 0) @(negedge clk);
        dq.push_back(e0);
        dq.push_back(e1);
        dq.push_back(e2);
        dq.push_back(e3);
        repeat (17) @(negedge clk);
    endtask

    task automatic hold(input logic v, input int n);
        btn = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic press_expect(input int n);
        btn = 1'b1;
        pq.push_back(cyc + 7);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sel        = 5'd0;
        bus.half       = 1'b0;
        bus.current_pc = 32'h0040_1A3C;
        for (int i = 0; i < 8; i++) bus.s[i] = {8{4'(i + 1)}};
        for (int i = 0; i < 10; i++) bus.t[i] = {8{4'(i + 6)}};
        bus.s[2] = 32'h1234_5678;
        bus.t[0] = 32'hBEEF_0000;
        bus.t[9] = 32'h9DC0_0000;
        // reset held with button pressed; the held press must not step
        btn = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 12);
        hold(1'b0, 10);
        // PC low half
        show(ent(0, 7'b1000110, 1), ent(1, 7'b0110000, 1), ent(2, 7'b0001000, 1), ent(3, 7'b1111001, 1));
        // s2 low half
        bus.sel = 5'd3;
        show(ent(0, 7'b0000000, 1), ent(1, 7'b1111000, 1), ent(2, 7'b0000010, 1), ent(3, 7'b0010010, 1));
        // t0 high half
        bus.sel  = 5'd9;
        bus.half = 1'b1;
        show(ent(0, 7'b0001110, 0), ent(1, 7'b0000110, 1), ent(2, 7'b0000110, 1), ent(3, 7'b0000011, 1));
        // t9 high half
        bus.sel = 5'd18;
        show(ent(0, 7'b1000000, 0), ent(1, 7'b1000110, 1), ent(2, 7'b0100001, 1), ent(3, 7'b0010000, 1));
        // invalid select shows dashes
        bus.sel = 5'd25;
        show(ent(0, 7'b0111111, 0), ent(1, 7'b0111111, 1), ent(2, 7'b0111111, 1), ent(3, 7'b0111111, 1));
        // clean press
        press_expect(20);
        hold(1'b0, 12);
        // press bounce then settle, release bounce
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 2);
        press_expect(10);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 12);
        // reset at edge 5 of a held press
        btn = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 20);
        hold(1'b0, 12);
        press_expect(12);
        hold(1'b0, 12);
        while (pq.size() > 0) begin
            int e;
            e = pq.pop_front();
            checks++;
            failures++;
            $display("FAIL step_missing got none want pulse at cyc=%0d", e);
        end
        while (dq.size() > 0) begin
            logic [11:0] e;
            e = dq.pop_front();
            checks++;
            failures++;
            $display("FAIL digit_missing got none want an=%b seg=%b dp=%b", e[11:8], e[7:1], e[0]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
